denise_bpl_serializer: RTL
==========================

Name: denise_bpl_serializer

Overview:
- Parametrised bitplane parallel-to-serial unit for the Denise pixel pipeline, successor to the fixed 16-bit OCS shifter.
- Holds one fetch word per plane and applies independent odd/even scroll delay at super-hires resolution.
- Serialises at lores, hires or shres rate and gates planes by a latched plane count.
- Feeds the playfield, collision and HAM logic.

Parameters:
- PLANES, 8, number of bitplanes (1..8).
- FETCH_W, 64, fetch word width per plane (16, 32 or 64).
- SCR_W, $clog2(FETCH_W)+2, scroll value width in shres pixels.

Ports:
- clk  in  1  28 MHz pixel clock.
- reset  in  1  synchronous, active-high.
- ph  in  2  pixel phase within the 7 MHz cycle; increments by 1 every clk and wraps 3->0.
- mode  in  2  0 = lores, 1 = hires, 2 = shres, 3 = treated as shres.
- bpl_wr  in  PLANES  per-plane BPLxDAT write strobe, sampled only when ph==3; bit 0 = BPL1DAT.
- data_in  in  FETCH_W  fetch data for the strobed plane(s).
- nplanes  in  4  plane count (BPU).
- scroll_odd  in  SCR_W  delay for planes 1,3,5,7 (indices 0,2,4,6), in clk cycles.
- scroll_even  in  SCR_W  delay for planes 2,4,6,8.
- bpldata  out  PLANES  serial pixel bit per plane.
- armed  out  1  high while either group has a pending parallel load.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset:
  - All holding registers, shifters and delay counters are cleared to 0.
  - Both group arm flags and the latched plane count are cleared to 0.
  - bpldata = 0 and armed = 0 on the cycle after reset is asserted.
  - Reset asserted mid-operation aborts any pending load.
- Holding: on ph==3 with bpl_wr[p]=1, hold[p] <= data_in. Several strobes in one cycle load all strobed planes.
- Arming: on ph==3 with bpl_wr[0]=1, in the same cycle:
  - nplanes is latched to lnp.
  - Both groups are armed.
  - cnt_odd <= scroll_odd and cnt_even <= scroll_even.
- Delay counting: each armed group with a nonzero counter decrements it every clk.
- Parallel load: when an armed group's counter is 0:
  - That group's shifters load from their holding registers.
  - The group disarms.
  - Load latency: cycle t+1+scroll after the BPL1DAT write cycle t.
- Loaded data: the parallel load uses hold contents as updated by the BPL1DAT write cycle. Later writes before the load also take effect.
- Re-arm: a BPL1DAT write while a group is armed reloads its counter and restarts the delay. No load is issued for the earlier arming.
- Shift enable:
  - lores: ph==3.
  - hires: ph==1 or ph==3.
  - shres: every clk.
  - Shift is MSB-first; zero is shifted in at the LSB.
  - Load and shift in the same cycle: load wins, and the loaded MSB is presented unshifted.
- Output: bpldata[p] = shifter[p][FETCH_W-1] when p < lnp, else 0. Registered-free combinational gate of registered state.
- Overrun: the shifter runs empty after FETCH_W shifts and then outputs 0 until the next load. No wrap-around or recirculation.
- armed = arm_odd | arm_even.
- Scroll values are sampled only at arming. Changes while armed are ignored.
- mode changes take effect on the next clk. An in-flight shifter continues at the new rate.
- Widths: counters are SCR_W bits, unsigned, with no underflow (they hold at 0). lnp comparison is unsigned 4-bit.

Test Plan:
- FETCH_W=16, lores, nplanes=1, scroll 0, write BPL1DAT=16'h8001 at ph==3 -> bpldata[0]=1 for clks t+1..t+4, then 0 for 56 clks, then 1 for 4 clks, then 0 thereafter.
- Same data, scroll_odd=5 -> first 1 appears at t+6. armed is high for clks t+1..t+5 and low at t+6.
- hires, 2 planes, hold[1]=16'hFFFF, scroll_even=2, scroll_odd=0, BPL1DAT=0 -> bpldata[1] rises 2 clks after bpldata[0] would load; each bit lasts 2 clks; 32-clk high run.
- nplanes=3 with all 8 planes written with 16'hFFFF -> bpldata[2:0]=3'b111 and bpldata[7:3]=0. Changing nplanes to 8 without a BPL1DAT write leaves outputs unchanged.
- Re-arm: scroll_odd=10, second BPL1DAT write 4 clks after the first -> exactly one load, at second write cycle +11.
- Reset asserted at clk t+3 of a scroll=8 arming -> armed=0 and bpldata=0 from t+4. No load occurs afterwards.

Source files
------------

// File: rtl/denise_bpl_serializer.sv
// Bitplane parallel-to-serial unit: per-plane fetch holding registers, odd/even scroll
// delay in shres pixels, and a rate-selectable MSB-first shifter gated by plane count.
module denise_bpl_serializer #(
  parameter int unsigned PLANES  = 8,
  parameter int unsigned FETCH_W = 64,
  parameter int unsigned SCR_W   = $clog2(FETCH_W) + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         ph,
  input  logic [1:0]         mode,
  input  logic [PLANES-1:0]  bpl_wr,
  input  logic [FETCH_W-1:0] data_in,
  input  logic [3:0]         nplanes,
  input  logic [SCR_W-1:0]   scroll_odd,
  input  logic [SCR_W-1:0]   scroll_even,
  output logic [PLANES-1:0]  bpldata,
  output logic               armed
);

  logic [FETCH_W-1:0] hold_q  [PLANES];
  logic [FETCH_W-1:0] hold_d  [PLANES];
  logic [FETCH_W-1:0] shift_q [PLANES];
  logic [SCR_W-1:0]   cnt_odd_q, cnt_even_q;
  logic               arm_odd_q, arm_even_q;
  logic [3:0]         lnp_q;
  logic               wr_slot, arm_req, shift_en, load_odd, load_even;

  always_comb begin
    wr_slot  = (ph == 2'd3);
    arm_req  = wr_slot & bpl_wr[0];
    shift_en = 1'b1;
    for (int p = 0; p < PLANES; p++) begin
      hold_d[p] = (wr_slot && bpl_wr[p]) ? data_in : hold_q[p];
    end
    case (mode)
      2'd0:    shift_en = (ph == 2'd3);
      2'd1:    shift_en = ph[0];
      default: shift_en = 1'b1;
    endcase
    // A zero scroll loads on the arming edge itself; otherwise load as the count expires.
    // A fresh arming always supersedes a pending one.
    load_odd  = arm_req ? (scroll_odd == '0)
                        : (arm_odd_q && (cnt_odd_q <= SCR_W'(1)));
    load_even = arm_req ? (scroll_even == '0)
                        : (arm_even_q && (cnt_even_q <= SCR_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PLANES; p++) begin
        hold_q[p]  <= '0;
        shift_q[p] <= '0;
      end
      cnt_odd_q  <= '0;
      cnt_even_q <= '0;
      arm_odd_q  <= 1'b0;
      arm_even_q <= 1'b0;
      lnp_q      <= '0;
    end else begin
      for (int p = 0; p < PLANES; p++) begin
        hold_q[p] <= hold_d[p];
        if ((p % 2 == 0) ? load_odd : load_even) begin
          shift_q[p] <= hold_d[p];
        end else if (shift_en) begin
          shift_q[p] <= {shift_q[p][FETCH_W-2:0], 1'b0};
        end
      end
      if (arm_req) begin
        lnp_q      <= nplanes;
        cnt_odd_q  <= scroll_odd;
        cnt_even_q <= scroll_even;
        arm_odd_q  <= (scroll_odd != '0);
        arm_even_q <= (scroll_even != '0);
      end else begin
        if (arm_odd_q) begin
          if (load_odd) begin
            arm_odd_q <= 1'b0;
            cnt_odd_q <= '0;
          end else begin
            cnt_odd_q <= cnt_odd_q - SCR_W'(1);
          end
        end
        if (arm_even_q) begin
          if (load_even) begin
            arm_even_q <= 1'b0;
            cnt_even_q <= '0;
          end else begin
            cnt_even_q <= cnt_even_q - SCR_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PLANES; p++) begin
      bpldata[p] = shift_q[p][FETCH_W-1] & (4'(p) < lnp_q);
    end
    armed = arm_odd_q | arm_even_q;
  end

endmodule
